// File: rtl/fft_peak_detect_pkg.sv
// Shared definitions for the FFT peak detector: default sizes, FSM states and the
// per-bin tag that travels alongside the power pipeline.
package fft_peak_detect_pkg;

  localparam int unsigned NPtsDefault  = 1024;
  localparam int unsigned Log2NDefault = 10;
  localparam int unsigned DwDefault    = 16;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Frame position flags carried with each accepted bin.
  typedef struct packed {
    logic first;
    logic last;
    logic search;
  } bin_tag_t;

endpackage

// File: rtl/fft_cmag_sq.sv
// Two-stage registered |X|^2 = re^2 + im^2 pipeline with valid, bin index and tag
// sideband delayed to match.
module fft_cmag_sq
  import fft_peak_detect_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned BW = Log2NDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  input  logic [BW-1:0]        bin_i,
  input  bin_tag_t             tag_i,
  output logic                 valid_o,
  output logic [2*DW-1:0]      pow_o,
  output logic [BW-1:0]        bin_o,
  output bin_tag_t             tag_o
);

  // A square of a DW-bit signed value never exceeds 2^(2*DW-2), so 2*DW-1 bits are exact.
  logic signed [2*DW-2:0] re_ext, im_ext;
  logic [2*DW-2:0]        re_sq_d, re_sq_q, im_sq_d, im_sq_q;
  logic                   valid1_q;
  logic [BW-1:0]          bin1_q;
  bin_tag_t               tag1_q;
  logic [2*DW-1:0]        pow_d, pow_q;
  logic                   valid2_q;
  logic [BW-1:0]          bin2_q;
  bin_tag_t               tag2_q;

  always_comb begin
    re_ext  = {{(DW-1){re_i[DW-1]}}, re_i};
    im_ext  = {{(DW-1){im_i[DW-1]}}, im_i};
    re_sq_d = re_ext * re_ext;
    im_sq_d = im_ext * im_ext;
    pow_d   = {1'b0, re_sq_q} + {1'b0, im_sq_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      re_sq_q  <= '0;
      im_sq_q  <= '0;
      valid1_q <= 1'b0;
      bin1_q   <= '0;
      tag1_q   <= '0;
      pow_q    <= '0;
      valid2_q <= 1'b0;
      bin2_q   <= '0;
      tag2_q   <= '0;
    end else begin
      re_sq_q  <= re_sq_d;
      im_sq_q  <= im_sq_d;
      valid1_q <= valid_i;
      bin1_q   <= bin_i;
      tag1_q   <= tag_i;
      pow_q    <= pow_d;
      valid2_q <= valid1_q;
      bin2_q   <= bin1_q;
      tag2_q   <= tag1_q;
    end
  end

  assign valid_o = valid2_q;
  assign pow_o   = pow_q;
  assign bin_o   = bin2_q;
  assign tag_o   = tag2_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin power stream and per-frame peak search over an FFT bin stream.
// Define HALF_SPECTRUM_EN to restrict the peak search to bins 0..N_PTS/2-1.
module fft_peak_detect
  import fft_peak_detect_pkg::*;
#(
  parameter int unsigned N_PTS = NPtsDefault,
  parameter int unsigned LOG2N = Log2NDefault,
  parameter int unsigned DW    = DwDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_valid,
  input  logic                 fft_sof,
  input  logic signed [DW-1:0] Xb_re,
  input  logic signed [DW-1:0] Xb_im,
  output logic                 pow_valid,
  output logic [2*DW-1:0]      pow_out,
  output logic [LOG2N-1:0]     pow_bin,
  output logic                 peak_valid,
  output logic [LOG2N-1:0]     peak_bin,
  output logic [2*DW-1:0]      peak_pow,
  output logic                 frame_err
);

  localparam logic [LOG2N-1:0] LastBin = LOG2N'(N_PTS - 1);
`ifdef HALF_SPECTRUM_EN
  localparam logic [LOG2N-1:0] HalfBin = LOG2N'(N_PTS / 2);
`endif

  state_e                 state_d, state_q;
  logic [LOG2N-1:0]       bin_d, bin_q;

  logic                   accept;
  logic [LOG2N-1:0]       acc_bin;
  bin_tag_t               acc_tag;
  logic                   abort;

  logic                   samp_valid_q;
  logic signed [DW-1:0]   samp_re_q, samp_im_q;
  logic [LOG2N-1:0]       samp_bin_q;
  bin_tag_t               samp_tag_q;
  logic                   frame_err_q;

  logic                   p_valid;
  logic [2*DW-1:0]        p_pow;
  logic [LOG2N-1:0]       p_bin;
  bin_tag_t               p_tag;

  logic [2*DW-1:0]        run_pow_d, run_pow_q, peak_pow_d, peak_pow_q;
  logic [LOG2N-1:0]       run_bin_d, run_bin_q, peak_bin_d, peak_bin_q;
  logic                   peak_valid_d, peak_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
    end
  end

  // bin_q holds the index the next non-sof sample will take.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    unique case (state_q)
      StIdle: begin
        if (fft_valid && fft_sof) begin
          state_d = StRun;
          bin_d   = LOG2N'(1);
        end
      end
      StRun: begin
        if (fft_valid) begin
          if (fft_sof) begin
            bin_d = LOG2N'(1);
          end else if (bin_q == LastBin) begin
            state_d = StIdle;
            bin_d   = '0;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    abort   = 1'b0;
    acc_bin = bin_q;
    unique case (state_q)
      StIdle: begin
        if (fft_valid && fft_sof) begin
          accept  = 1'b1;
          acc_bin = '0;
        end
      end
      StRun: begin
        if (fft_valid) begin
          accept = 1'b1;
          if (fft_sof) begin
            abort   = 1'b1;
            acc_bin = '0;
          end
        end
      end
      default: ;
    endcase
    acc_tag.first = (acc_bin == '0);
    acc_tag.last  = (acc_bin == LastBin);
`ifdef HALF_SPECTRUM_EN
    acc_tag.search = (acc_bin < HalfBin);
`else
    acc_tag.search = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_valid_q <= 1'b0;
      samp_re_q    <= '0;
      samp_im_q    <= '0;
      samp_bin_q   <= '0;
      samp_tag_q   <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      samp_valid_q <= accept;
      samp_re_q    <= Xb_re;
      samp_im_q    <= Xb_im;
      samp_bin_q   <= acc_bin;
      samp_tag_q   <= acc_tag;
      frame_err_q  <= abort;
    end
  end

  fft_cmag_sq #(
    .DW (DW),
    .BW (LOG2N)
  ) u_cmag_sq (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (samp_valid_q),
    .re_i    (samp_re_q),
    .im_i    (samp_im_q),
    .bin_i   (samp_bin_q),
    .tag_i   (samp_tag_q),
    .valid_o (p_valid),
    .pow_o   (p_pow),
    .bin_o   (p_bin),
    .tag_o   (p_tag)
  );

  // Bin 0 reloads the running max, which also discards any aborted frame's max.
  always_comb begin
    run_pow_d    = run_pow_q;
    run_bin_d    = run_bin_q;
    peak_valid_d = 1'b0;
    peak_pow_d   = peak_pow_q;
    peak_bin_d   = peak_bin_q;
    if (p_valid) begin
      if (p_tag.first) begin
        run_pow_d = p_pow;
        run_bin_d = p_bin;
      end else if (p_tag.search && (p_pow > run_pow_q)) begin
        run_pow_d = p_pow;
        run_bin_d = p_bin;
      end
      if (p_tag.last) begin
        peak_valid_d = 1'b1;
        peak_pow_d   = run_pow_d;
        peak_bin_d   = run_bin_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_pow_q    <= '0;
      run_bin_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_pow_q   <= '0;
      peak_bin_q   <= '0;
    end else begin
      run_pow_q    <= run_pow_d;
      run_bin_q    <= run_bin_d;
      peak_valid_q <= peak_valid_d;
      peak_pow_q   <= peak_pow_d;
      peak_bin_q   <= peak_bin_d;
    end
  end

  assign pow_valid  = p_valid;
  assign pow_out    = p_pow;
  assign pow_bin    = p_bin;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_pow   = peak_pow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect; expectations follow HALF_SPECTRUM_EN.
module tb_fft_peak_detect;

  localparam int unsigned NPts  = 1024;
  localparam int unsigned Log2N = 10;
  localparam int unsigned Dw    = 16;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic                 fft_valid = 1'b0;
  logic                 fft_sof   = 1'b0;
  logic signed [Dw-1:0] Xb_re     = '0;
  logic signed [Dw-1:0] Xb_im     = '0;
  logic                 tb_last   = 1'b0;
  logic                 pow_valid;
  logic [2*Dw-1:0]      pow_out;
  logic [Log2N-1:0]     pow_bin;
  logic                 peak_valid;
  logic [Log2N-1:0]     peak_bin;
  logic [2*Dw-1:0]      peak_pow;
  logic                 frame_err;

  fft_peak_detect #(
    .N_PTS (NPts),
    .LOG2N (Log2N),
    .DW    (Dw)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fft_valid  (fft_valid),
    .fft_sof    (fft_sof),
    .Xb_re      (Xb_re),
    .Xb_im      (Xb_im),
    .pow_valid  (pow_valid),
    .pow_out    (pow_out),
    .pow_bin    (pow_bin),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_pow   (peak_pow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          re_arr[NPts];
  int          im_arr[NPts];
  logic [31:0] pow_seen[NPts];

  int          edge_n = 0, last_edge = -100;
  int          pow_cnt = 0, pk_cnt = 0, pk_edge = 0, pk_prev_edge = 0, pk_delay = 0;
  int          fe_cnt = 0, fe_wide = 0;
  logic [31:0] pk_pow_seen = '0;
  logic [9:0]  pk_bin_seen = '0;
  logic        fe_prev = 1'b0;
  logic        in_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive(input int re, input int im, input logic v, input logic sof,
                       input logic last);
    @(negedge clk);
    fft_valid = v;
    fft_sof   = sof;
    Xb_re     = Dw'(re);
    Xb_im     = Dw'(im);
    tb_last   = last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_arr();
    for (int b = 0; b < NPts; b++) begin
      re_arr[b] = 0;
      im_arr[b] = 0;
    end
  endtask

  task automatic send_bins(input int n, input bit gaps);
    for (int b = 0; b < n; b++) begin
      drive(re_arr[b], im_arr[b], 1'b1, b == 0, b == NPts - 1);
      if (gaps) drive(0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Event monitor: samples DUT outputs 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    in_last = fft_valid && tb_last && !rst;
    edge_n++;
    #1;
    if (in_last) last_edge = edge_n;
    if (pow_valid) begin
      pow_seen[pow_bin] = pow_out;
      pow_cnt++;
    end
    if (peak_valid) begin
      pk_cnt++;
      pk_prev_edge = pk_edge;
      pk_edge      = edge_n;
      pk_delay     = edge_n - last_edge;
      pk_bin_seen  = peak_bin;
      pk_pow_seen  = peak_pow;
    end
    if (frame_err && fe_prev) fe_wide++;
    if (frame_err && !fe_prev) fe_cnt++;
    fe_prev = frame_err;
  end

  int          pow0, pk0, fe0;
  logic [9:0]  exp_bin;
  logic [31:0] exp_pow;

  initial begin
    clear_arr();
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_pow_valid", 64'(pow_valid), 64'd0);
    check_eq("rst_pow_out", 64'(pow_out), 64'd0);
    check_eq("rst_pow_bin", 64'(pow_bin), 64'd0);
    check_eq("rst_peak_valid", 64'(peak_valid), 64'd0);
    check_eq("rst_peak_bin", 64'(peak_bin), 64'd0);
    check_eq("rst_peak_pow", 64'(peak_pow), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Valid samples without a start of frame are ignored in IDLE.
    for (int i = 0; i < 8; i++) drive(999, 999, 1'b1, 1'b0, 1'b0);
    idle(5);
    check_eq("idle_ignore_pow_cnt", 64'(pow_cnt), 64'd0);

    // Reset mid-stream: bins 0..297 reach the pow stream, 298/299 are flushed.
    for (int b = 0; b < NPts; b++) re_arr[b] = (b % 100) + 1;
    pow0 = pow_cnt;
    send_bins(300, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_outs_zero",
             64'({pow_valid, pow_out, pow_bin, peak_valid, peak_bin, peak_pow, frame_err}),
             64'd0);
    @(negedge clk);
    rst       = 1'b0;
    fft_valid = 1'b0;
    tb_last   = 1'b0;
    check_eq("midrst_flush_pow_cnt", 64'(pow_cnt - pow0), 64'd298);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_no_pulse", 64'({pow_valid, peak_valid, frame_err}), 64'd0);
    end
    check_eq("post_rst_no_peak", 64'(pk_cnt), 64'd0);

    // Single tone at bin 10.
    clear_arr();
    re_arr[10] = 1000;
    pk0  = pk_cnt;
    pow0 = pow_cnt;
    send_bins(NPts, 1'b0);
    idle(6);
    check_eq("tone_peak_cnt", 64'(pk_cnt - pk0), 64'd1);
    check_eq("tone_peak_bin", 64'(pk_bin_seen), 64'd10);
    check_eq("tone_peak_pow", 64'(pk_pow_seen), 64'd1000000);
    check_eq("tone_peak_latency", 64'(pk_delay), 64'd3);
    check_eq("tone_pow_bin10", 64'(pow_seen[10]), 64'd1000000);
    check_eq("tone_pow_cnt", 64'(pow_cnt - pow0), 64'(NPts));
    check_eq("tone_peak_hold_bin", 64'(peak_bin), 64'd10);
    check_eq("tone_peak_pulse_done", 64'(peak_valid), 64'd0);

    // Full-scale negative corner at bin 5, with and without input gaps.
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < NPts; b++) begin
        re_arr[b] = b % 7;
        im_arr[b] = -(b % 5);
      end
      re_arr[5] = -32768;
      im_arr[5] = -32768;
      pk0 = pk_cnt;
      send_bins(NPts, g == 0);
      idle(6);
      check_eq("corner_pow_bin5", 64'(pow_seen[5]), 64'h8000_0000);
      check_eq("corner_pow_bin12", 64'(pow_seen[12]), 64'd29);
      check_eq("corner_peak_cnt", 64'(pk_cnt - pk0), 64'd1);
      check_eq("corner_peak_bin", 64'(pk_bin_seen), 64'd5);
      check_eq("corner_peak_pow", 64'(pk_pow_seen), 64'h8000_0000);
    end

    // Tie between bins 3 and 300 keeps the lower bin.
    clear_arr();
    re_arr[3]   = 200;
    im_arr[3]   = 200;
    re_arr[300] = 200;
    im_arr[300] = 200;
    send_bins(NPts, 1'b0);
    idle(6);
    check_eq("tie_peak_bin", 64'(pk_bin_seen), 64'd3);
    check_eq("tie_peak_pow", 64'(pk_pow_seen), 64'd80000);

    // Frame aborted at bin 500 by a new sof; its large bin 100 must not survive.
    clear_arr();
    re_arr[100] = 3000;
    fe0 = fe_cnt;
    pk0 = pk_cnt;
    send_bins(500, 1'b0);
    clear_arr();
    re_arr[7] = 50;
    im_arr[7] = 50;
    send_bins(NPts, 1'b0);
    idle(6);
    check_eq("abort_frame_err_cnt", 64'(fe_cnt - fe0), 64'd1);
    check_eq("abort_frame_err_width", 64'(fe_wide), 64'd0);
    check_eq("abort_peak_cnt", 64'(pk_cnt - pk0), 64'd1);
    check_eq("abort_peak_bin", 64'(pk_bin_seen), 64'd7);
    check_eq("abort_peak_pow", 64'(pk_pow_seen), 64'd5000);

    // Back-to-back frames, no dead cycle.
    fe0 = fe_cnt;
    pk0 = pk_cnt;
    send_bins(NPts, 1'b0);
    send_bins(NPts, 1'b0);
    idle(6);
    check_eq("b2b_peak_cnt", 64'(pk_cnt - pk0), 64'd2);
    check_eq("b2b_peak_spacing", 64'(pk_edge - pk_prev_edge), 64'(NPts));
    check_eq("b2b_peak_bin", 64'(pk_bin_seen), 64'd7);
    check_eq("b2b_no_frame_err", 64'(fe_cnt - fe0), 64'd0);

    // Mirrored-half energy: search range decides the winner.
    clear_arr();
    re_arr[1014] = 5000;
    re_arr[10]   = 100;
`ifdef HALF_SPECTRUM_EN
    exp_bin = 10'd10;
    exp_pow = 32'd10000;
`else
    exp_bin = 10'd1014;
    exp_pow = 32'd25000000;
`endif
    send_bins(NPts, 1'b0);
    idle(6);
    check_eq("half_peak_bin", 64'(pk_bin_seen), 64'(exp_bin));
    check_eq("half_peak_pow", 64'(pk_pow_seen), 64'(exp_pow));
    check_eq("half_pow_bin1014", 64'(pow_seen[1014]), 64'd25000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
